// File: rtl/adder_arbiter_pkg.sv
// Shared constants, types and helpers for the two-requester adder arbiter.
package adder_arbiter_pkg;

    localparam int DATA_W             = 64;
    localparam int TAG_W              = 4;
    localparam int CNT_W              = 4;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [0:0] {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

    // Two's-complement overflow: operands agree in sign, the result does not.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester, response and status signals of the adder arbiter grouped as one bus.
interface adder_arbiter_if;
    import adder_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [TAG_W-1:0]  req1_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_src;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_of;

    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_src, rsp_tag, rsp_sum, rsp_of, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        output req1_valid, req1_a, req1_b, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_src, rsp_tag, rsp_sum, rsp_of, busy
    );

endinterface

// File: rtl/adder_arbiter_adder.sv
// Gate-level ripple-carry 64-bit adder; sum and overflow read zero when not enabled.
module adder_arbiter_adder
    import adder_arbiter_pkg::*;
(
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              of_o
);

    logic [DATA_W-1:0] carry_s;
    logic [DATA_W-1:0] raw_s;

    assign carry_s[0] = 1'b0;

    // The carry out of the top bit is never formed: results wrap modulo 2^64.
    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        assign raw_s[i] = a_i[i] ^ b_i[i] ^ carry_s[i];
        if (i < DATA_W - 1) begin : g_carry
            assign carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o = en_i ? raw_s : {DATA_W{1'b0}};
    assign of_o  = en_i & add_overflow(a_i[DATA_W-1], b_i[DATA_W-1], raw_s[DATA_W-1]);

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder behind a one-entry result register.
// Default: fixed priority with starvation guard; define ADDER_ARB_RR_EN for round-robin.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
)
(
    input  logic            clk,
    input  logic            rst_n,
    adder_arbiter_if.slave  bus
);

    logic              can_accept_s;
    logic              accept_s;
    req_idx_e          grant_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [TAG_W-1:0]  op_tag_s;
    logic [DATA_W-1:0] sum_s;
    logic              of_s;

    logic              rsp_valid_q, rsp_valid_d;
    req_idx_e          rsp_src_q,   rsp_src_d;
    logic [TAG_W-1:0]  rsp_tag_q,   rsp_tag_d;
    logic [DATA_W-1:0] rsp_sum_q,   rsp_sum_d;
    logic              rsp_of_q,    rsp_of_d;

`ifdef ADDER_ARB_RR_EN
    req_idx_e          last_grant_q, last_grant_d;
`else
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0]  starve_q, starve_d;
`endif

    // Grant selection; depends only on valids and arbiter state, never on operands.
    always_comb begin
        grant_s = REQ0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ADDER_ARB_RR_EN
            grant_s = (last_grant_q == REQ0) ? REQ1 : REQ0;
`else
            grant_s = (starve_q == STARVE_LIM) ? REQ1 : REQ0;
`endif
        end else if (bus.req1_valid) begin
            grant_s = REQ1;
        end else begin
            grant_s = REQ0;
        end
    end

    // Holding rst_n in the ready path keeps requesters off the bus during reset.
    assign can_accept_s   = rst_n & (~rsp_valid_q | bus.rsp_ready);
    assign bus.req0_ready = can_accept_s & (grant_s == REQ0);
    assign bus.req1_ready = can_accept_s & (grant_s == REQ1);
    assign accept_s       = can_accept_s & ((grant_s == REQ0) ? bus.req0_valid : bus.req1_valid);

    assign op_a_s   = (grant_s == REQ0) ? bus.req0_a   : bus.req1_a;
    assign op_b_s   = (grant_s == REQ0) ? bus.req0_b   : bus.req1_b;
    assign op_tag_s = (grant_s == REQ0) ? bus.req0_tag : bus.req1_tag;

    adder_arbiter_adder u_adder (
        .en_i  (accept_s),
        .a_i   (op_a_s),
        .b_i   (op_b_s),
        .sum_o (sum_s),
        .of_o  (of_s)
    );

    // Result register: load on accept, drop when consumed, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_src_d   = rsp_src_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_of_d    = rsp_of_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_src_d   = grant_s;
            rsp_tag_d   = op_tag_s;
            rsp_sum_d   = sum_s;
            rsp_of_d    = of_s;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

`ifdef ADDER_ARB_RR_EN
    // Remember the most recent winner so contention alternates.
    always_comb begin
        if (accept_s) begin
            last_grant_d = grant_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end
`else
    // Count req0 wins that blocked a waiting req1; stalls leave the count alone.
    always_comb begin
        starve_d = starve_q;
        if (accept_s && (grant_s == REQ1)) begin
            starve_d = {CNT_W{1'b0}};
        end else if (!bus.req1_valid) begin
            starve_d = {CNT_W{1'b0}};
        end else if (accept_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end
`endif

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_src_q    <= REQ0;
            rsp_tag_q    <= {TAG_W{1'b0}};
            rsp_sum_q    <= {DATA_W{1'b0}};
            rsp_of_q     <= 1'b0;
`ifdef ADDER_ARB_RR_EN
            last_grant_q <= REQ1;
`else
            starve_q     <= {CNT_W{1'b0}};
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_src_q    <= rsp_src_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_of_q     <= rsp_of_d;
`ifdef ADDER_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_q     <= starve_d;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_src   = rsp_src_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_of    = rsp_of_q;
    assign bus.busy      = rsp_valid_q | bus.req0_valid | bus.req1_valid;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed vectors push expected results, a monitor pops them on handshake.
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    typedef struct packed {
        logic        src;
        logic [3:0]  tag;
        logic [63:0] sum;
        logic        of;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if bus();

    adder_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;
    bit   prev_acc = 1'b0;
    int   seq[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_src", 64'(bus.rsp_src), 64'(e.src));
                check("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
                check("rsp_sum", bus.rsp_sum, e.sum);
                check("rsp_of",  64'(bus.rsp_of),  64'(e.of));
            end
        end
    end

    // One cycle of stimulus; g is the expected grant (-1 when nothing is accepted).
    task automatic step(input logic v0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] t0,
                        input logic v1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] t1,
                        input logic rdy, input int g, input logic [63:0] es, input logic eo);
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_acc) check("rsp_valid_latency", 64'(bus.rsp_valid), 64'd1);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_tag = t1;
        bus.rsp_ready  = rdy;
        #1;
        if (v0 || v1) begin
            check("req0_ready", 64'(bus.req0_ready), 64'(g == 0));
            check("req1_ready", 64'(bus.req1_ready), 64'(g == 1));
        end
        prev_acc = (g >= 0);
        if (g >= 0) begin
            e.src = g[0];
            e.tag = (g == 0) ? t0 : t1;
            e.sum = es;
            e.of  = eo;
            sb.push_back(e);
            last_exp = e;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a0, b0, a1, b1, es;
`ifdef ADDER_ARB_RR_EN
        seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`endif
        bus.req0_valid = 1'b1; bus.req0_a = 64'd1; bus.req0_b = 64'd1; bus.req0_tag = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 64'd1; bus.req1_b = 64'd1; bus.req1_tag = 4'd2;
        bus.rsp_ready  = 1'b1;
        #3;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_sum",   bus.rsp_sum, 64'd0);
        check("rst_rsp_tag",   64'(bus.rsp_tag), 64'd0);
        check("rst_rsp_src",   64'(bus.rsp_src), 64'd0);
        check("rst_rsp_of",    64'(bus.rsp_of), 64'd0);
        check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters valid continuously, with a three-cycle output stall after eight grants.
        for (int i = 0; i < 12; i++) begin
            a0 = 64'(i) * 64'd3;    b0 = 64'd10;
            a1 = 64'(i) * 64'd1000; b1 = 64'd7;
            if (i == 8) begin
                for (int s = 0; s < 3; s++) begin
                    step(1'b1, a0, b0, 4'(i), 1'b1, a1, b1, 4'(i + 8), 1'b0, -1, 64'd0, 1'b0);
                    check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                    check("stall_rsp_sum",   bus.rsp_sum, last_exp.sum);
                    check("stall_rsp_tag",   64'(bus.rsp_tag), 64'(last_exp.tag));
                    check("stall_rsp_src",   64'(bus.rsp_src), 64'(last_exp.src));
                end
            end
            es = (seq[i] == 0) ? (a0 + b0) : (a1 + b1);
            step(1'b1, a0, b0, 4'(i), 1'b1, a1, b1, 4'(i + 8), 1'b1, seq[i], es, 1'b0);
        end

        // Single requesters, including overflow and wrap boundaries.
        step(1'b1, 64'd5, 64'd7, 4'd3, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 0, 64'd12, 1'b0);
        step(1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd9, 1'b1,
             1, 64'h8000_0000_0000_0000, 1'b1);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1,
             0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        step(1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd15, 1'b1,
             1, 64'd0, 1'b1);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 0, 64'd0, 1'b0);

        // Idle with the consumer ready: result drains, then busy falls.
        step(1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, -1, 64'd0, 1'b0);
        check("busy_draining", 64'(bus.busy), 64'd1);
        step(1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, -1, 64'd0, 1'b0);
        check("rsp_valid_drained", 64'(bus.rsp_valid), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);

        // Reset while a result is held.
        step(1'b1, 64'd20, 64'd22, 4'd6, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 0, 64'd42, 1'b0);
        @(posedge clk);
        #1;
        check("held_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        bus.req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_rsp_sum",   bus.rsp_sum, 64'd0);
        check("midrst_rsp_tag",   64'(bus.rsp_tag), 64'd0);
        check("midrst_req0_ready", 64'(bus.req0_ready), 64'd0);
        check("midrst_req1_ready", 64'(bus.req1_ready), 64'd0);
        sb.delete();
        prev_acc = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 64'd100, 64'd1, 4'd10, 1'b1, 64'd200, 64'd2, 4'd11, 1'b1, 0, 64'd101, 1'b0);

        step(1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, -1, 64'd0, 1'b0);
        step(1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, -1, 64'd0, 1'b0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive req1-blocked req0 grants before req1 is forced (fixed-priority mode only; range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  operation of requester N accepted this cycle when valid&ready.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  64  addend operands.
REQ-007 req0_tag / req1_tag  input  4  opaque ID returned with result.
REQ-008 rsp_valid  output  1  result register holds a valid result.
REQ-009 rsp_ready  input  1  consumer takes result when rsp_valid&rsp_ready.
REQ-010 rsp_src  output  1  requester index of held result.
REQ-011 rsp_tag  output  4  tag of held result.
REQ-012 rsp_sum  output  64  A+B modulo 2^64.
REQ-013 rsp_of  output  1  two's-complement signed overflow of A+B.
REQ-014 busy  output  1  rsp_valid OR any req valid.

Function
REQ-015 One shared 64-bit adder; at most one operation accepted per cycle.
REQ-016 can_accept = !rsp_valid | rsp_ready (one-entry output register, full throughput when drained every cycle).
REQ-017 reqN_ready = can_accept & (grant==N); ready derived combinationally from valids and arbiter state, never from reqN_a/b/tag; no valid depends on ready.
REQ-018 Adder enable asserted only in accept cycles; operands muxed from granted requester.
REQ-019 Latency: accept in cycle T -> rsp_valid=1 with sum/of/src/tag at T+1.
REQ-020 Output register holds values stable while rsp_valid & !rsp_ready.
REQ-021 No accept cycle and rsp_ready=1 -> rsp_valid falls next cycle.
REQ-022 Single valid requester granted regardless of arbitration state.
REQ-023 Both valid, fixed mode: req0 granted unless starve_cnt==STARVE_MAX, then req1 granted.
REQ-024 starve_cnt (4 bits): +1 on req0 accept while req1_valid=1; cleared on req1 accept or when req1_valid=0; saturates at STARVE_MAX.
REQ-025 Arbiter state (counter/last_grant) updates only on accept cycles or per REQ-024 clearing; stall cycles (can_accept=0) freeze it.
REQ-026 rsp_of = (a[63]==b[63]) & (sum[63]!=a[63]); 0x7FFF_FFFF_FFFF_FFFF+1 -> of=1; carry-out discarded.

Reset
REQ-027 rst_n=0 forces immediately: rsp_valid=0, rsp_src=0, rsp_tag=0, rsp_sum=0, rsp_of=0, starve_cnt=0, last_grant=1.
REQ-028 Reset mid-operation discards held result; no ready asserted while rst_n=0.
REQ-029 First accept after reset release occurs no earlier than first rising edge with rst_n=1.

Configuration
REQ-030 Macro ADDER_ARB_RR_EN defined: both-valid case alternates via last_grant register (grant != last_grant), last_grant updated on every accept; starve_cnt and STARVE_MAX unused.
REQ-031 Macro undefined: fixed priority with starvation counter per REQ-023/024.

Structure
REQ-032 Shared package holds: data width constant (64), tag width constant (4), requester index type, STARVE_MAX default.
REQ-033 One sub-module: the team's existing gate-level 64-bit Adder (enable-gated sum and overflow), instantiated once; no second adder.

Verification
REQ-034 req0 only, a=5,b=7,tag=3, rsp_ready=1 -> next cycle rsp_valid=1, sum=12, src=0, tag=3, of=0.
REQ-035 a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, of=1; a=b=0xFFFF_FFFF_FFFF_FFFF -> sum=0xFFFF_FFFF_FFFF_FFFE, of=0.
REQ-036 Fixed mode, both valid continuously, STARVE_MAX=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-037 ADDER_ARB_RR_EN, both valid continuously -> grant sequence 0,1,0,1 after reset.
REQ-038 rsp_ready=0 three cycles with both valid -> both readys 0, rsp outputs frozen, starve_cnt unchanged; rsp_ready=1 -> drain and accept same cycle.
REQ-039 rst_n low while rsp_valid=1 -> rsp_valid=0 asynchronously, all outputs zero, first post-reset both-valid grant = 0.
